// File: rtl/sobel_stream_filter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sobel_stream_filter
// Streaming 3x3 Sobel edge detector. Pixels arrive in raster order with
// optional gaps (iValid low). Two line buffers plus a 3x3 window register
// form the neighbourhood. Every interior pixel produces the saturated
// (|Gx|+|Gy|) >> MAG_SHIFT three cycles after the pixel that completes its
// window is accepted.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   iStart     first pixel of a frame (qualified by iValid)
//   iValid     iData valid; no backpressure
//   iData      input pixel
//   iThresh    binarisation threshold (only with SOBEL_THRESH_EN)
//   oData      edge magnitude (or binary edge map with SOBEL_THRESH_EN)
//   oValid     oData valid
//   oStart     first output pixel of a frame
//   oEnd       last output pixel of a completed frame
//   oFrameErr  one-cycle pulse when a frame is aborted by a new iStart
//
// Optional build macro: SOBEL_THRESH_EN adds iThresh and makes oData binary.
// ---------------------------------------------------------------------------
module sobel_stream_filter #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int MAG_SHIFT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iStart,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
`ifdef SOBEL_THRESH_EN
    input  logic [DATA_W-1:0] iThresh,
`endif
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oStart,
    output logic              oEnd,
    output logic              oFrameErr
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 4;
    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return {3'b000, p};
    endfunction

    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
        logic [GW-1:0] r;
        if (v[GW-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, pos_col_s;
    logic [RW-1:0]     row_q, row_d, pos_row_s;
    logic              start_pix_s, accept_s;
    logic              err_q, err_d;
    logic              v1_q, v1_d, s1_q, s1_d, e1_q, e1_d;
    logic              v2_q, s2_q, e2_q;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [GW-1:0]     xr_s, xl_s, yb_s, yt_s;
    logic [MW-1:0]     mag_s, shifted_s;
    logic [DATA_W-1:0] sat_s, pix_s;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              ovalid_q, ostart_q, oend_q;

    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb1_d [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] lb2_d [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];

    // Frame position tracking, acceptance and window-completion flags.
    always_comb begin
        start_pix_s = iValid & iStart;
        accept_s    = iValid & (iStart | (state_q == ST_ACTIVE));
        // A start pixel is always (0,0), even when it aborts a running frame.
        if (start_pix_s) begin
            pos_col_s = {CW{1'b0}};
            pos_row_s = {RW{1'b0}};
        end else begin
            pos_col_s = col_q;
            pos_row_s = row_q;
        end
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept_s) begin
            state_d = ST_ACTIVE;
            if (pos_col_s == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (pos_row_s == ROW_LAST) begin
                    row_d   = {RW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    row_d = pos_row_s + RW'(1);
                end
            end else begin
                col_d = pos_col_s + CW'(1);
                row_d = pos_row_s;
            end
        end else begin
            state_d = state_q;
        end
        err_d = start_pix_s & (state_q == ST_ACTIVE);
        v1_d  = accept_s & (pos_row_s >= RW'(2)) & (pos_col_s >= CW'(2));
        s1_d  = accept_s & (pos_row_s == RW'(2)) & (pos_col_s == CW'(2));
        e1_d  = accept_s & (pos_row_s == ROW_LAST) & (pos_col_s == COL_LAST);
    end

    // Line buffers and window shift on accepted pixels only.
    always_comb begin
        lb1_d = lb1_q;
        lb2_d = lb2_q;
        win_d = win_q;
        if (accept_s) begin
            lb1_d[0] = iData;
            lb2_d[0] = lb1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1_d[i] = lb1_q[i-1];
                lb2_d[i] = lb2_q[i-1];
            end
            for (int y = 0; y < 3; y++) begin
                win_d[y][0] = win_q[y][1];
                win_d[y][1] = win_q[y][2];
            end
            // Oldest entry of each line buffer is the same column one/two rows up.
            win_d[0][2] = lb2_q[IMG_W-1];
            win_d[1][2] = lb1_q[IMG_W-1];
            win_d[2][2] = iData;
        end else begin
            lb1_d = lb1_q;
            lb2_d = lb2_q;
            win_d = win_q;
        end
    end

    // Gradients, magnitude, scaling, saturation and output selection.
    always_comb begin
        xr_s = ext(win_q[0][2]) + (ext(win_q[1][2]) << 1) + ext(win_q[2][2]);
        xl_s = ext(win_q[0][0]) + (ext(win_q[1][0]) << 1) + ext(win_q[2][0]);
        yb_s = ext(win_q[2][0]) + (ext(win_q[2][1]) << 1) + ext(win_q[2][2]);
        yt_s = ext(win_q[0][0]) + (ext(win_q[0][1]) << 1) + ext(win_q[0][2]);
        gx_d = signed'(xr_s - xl_s);
        gy_d = signed'(yb_s - yt_s);
        mag_s     = {1'b0, abs_g(gx_q)} + {1'b0, abs_g(gy_q)};
        shifted_s = mag_s >> MAG_SHIFT;
        if (shifted_s > {4'b0000, PIX_MAX}) begin
            sat_s = PIX_MAX;
        end else begin
            sat_s = shifted_s[DATA_W-1:0];
        end
`ifdef SOBEL_THRESH_EN
        if (sat_s >= iThresh) begin
            pix_s = PIX_MAX;
        end else begin
            pix_s = {DATA_W{1'b0}};
        end
`else
        pix_s = sat_s;
`endif
        if (v2_q) begin
            odata_d = pix_s;
        end else begin
            odata_d = {DATA_W{1'b0}};
        end
    end

    // Pixel storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        lb1_q <= lb1_d;
        lb2_q <= lb2_d;
        win_q <= win_d;
    end

    // Control state, pipeline stages and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            col_q    <= {CW{1'b0}};
            row_q    <= {RW{1'b0}};
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            s1_q     <= 1'b0;
            e1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s2_q     <= 1'b0;
            e2_q     <= 1'b0;
            gx_q     <= {GW{1'b0}};
            gy_q     <= {GW{1'b0}};
            odata_q  <= {DATA_W{1'b0}};
            ovalid_q <= 1'b0;
            ostart_q <= 1'b0;
            oend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
            v1_q     <= v1_d;
            s1_q     <= s1_d;
            e1_q     <= e1_d;
            v2_q     <= v1_q;
            s2_q     <= s1_q;
            e2_q     <= e1_q;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            odata_q  <= odata_d;
            ovalid_q <= v2_q;
            ostart_q <= v2_q & s2_q;
            oend_q   <= v2_q & e2_q;
        end
    end

    assign oData     = odata_q;
    assign oValid    = ovalid_q;
    assign oStart    = ostart_q;
    assign oEnd      = oend_q;
    assign oFrameErr = err_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
`timescale 1ns/1ps
// Self-checking bench for sobel_stream_filter: two instances (MAG_SHIFT 0
// and 2) share one 8x6 input stream; expected outputs come from a direct
// Sobel computation over the frame image plus a fixed 3-cycle latency rule.
module tb_sobel_stream_filter;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int d;
        bit st;
        bit out;
        int v0;
        int v2;
        bit os;
        bit oe;
        bit err;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start, i_valid;
    logic [7:0] i_data;
    logic [7:0] o_data0, o_data2;
    logic       o_valid0, o_start0, o_end0, o_err0;
    logic       o_valid2, o_start2, o_end2, o_err2;
`ifdef SOBEL_THRESH_EN
    logic [7:0] i_thresh = 8'd0;
`endif

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  out_cnt, end_cnt, err_cnt;
    int  img [H][W];
    ev_t evq [$];
    bit  thr_en = 1'b0;
    int  thr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .MAG_SHIFT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .iStart(i_start), .iValid(i_valid), .iData(i_data),
`ifdef SOBEL_THRESH_EN
        .iThresh(i_thresh),
`endif
        .oData(o_data0), .oValid(o_valid0), .oStart(o_start0), .oEnd(o_end0),
        .oFrameErr(o_err0)
    );

    sobel_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .MAG_SHIFT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .iStart(i_start), .iValid(i_valid), .iData(i_data),
`ifdef SOBEL_THRESH_EN
        .iThresh(i_thresh),
`endif
        .oData(o_data2), .oValid(o_valid2), .oStart(o_start2), .oEnd(o_end2),
        .oFrameErr(o_err2)
    );

    // Sobel magnitude for centre (r,c) of the current image.
    function automatic int sob(int r, int c, int sh);
        int gx, gy, mag;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> sh;
        if (mag > 255) mag = 255;
        if (thr_en) mag = (mag >= thr) ? 255 : 0;
        return mag;
    endfunction

    function automatic void fill_image(int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0: img[r][c] = 50;
                    1: img[r][c] = (c >= 4) ? 100 : 0;
                    2: img[r][c] = 10 * c;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
    endfunction

    // Queue the first npix raster pixels of the current image.
    function automatic void add_frame(int npix, bit restart);
        ev_t e;
        for (int k = 0; k < npix; k++) begin
            int r, c;
            r = k / W;
            c = k % W;
            e.d   = img[r][c];
            e.st  = (k == 0);
            e.out = (r >= 2) && (c >= 2);
            e.v0  = e.out ? sob(r-1, c-1, 0) : 0;
            e.v2  = e.out ? sob(r-1, c-1, 2) : 0;
            e.os  = (r == 2) && (c == 2);
            e.oe  = (r == H-1) && (c == W-1);
            e.err = restart && (k == 0);
            evq.push_back(e);
        end
    endfunction

    // Valid pixels without iStart while idle; they must produce nothing.
    function automatic void add_junk(int n);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            e.d = int'($urandom_range(255));
            e.st = 1'b0; e.out = 1'b0; e.v0 = 0; e.v2 = 0;
            e.os = 1'b0; e.oe = 1'b0; e.err = 1'b0;
            evq.push_back(e);
        end
    endfunction

    // Drive queued pixels with random gaps; check every cycle's outputs.
    task automatic play(int gap_pct);
        int   due_q [$];
        ev_t  pend_q [$];
        int   err_q [$];
        int   idx, guard;
        bit   exp_v, exp_e;
        ev_t  e;
        idx = 0; guard = 0;
        out_cnt = 0; end_cnt = 0; err_cnt = 0;
        while ((idx < evq.size() || due_q.size() > 0 || err_q.size() > 0) && guard < 4000) begin
            guard++;
            @(posedge clk); #1;
            if (idx < evq.size() && int'($urandom_range(99)) >= gap_pct) begin
                i_valid = 1'b1;
                i_start = evq[idx].st;
                i_data  = 8'(evq[idx].d);
                if (evq[idx].out) begin
                    due_q.push_back(cyc + 3);
                    pend_q.push_back(evq[idx]);
                end
                if (evq[idx].err) err_q.push_back(cyc + 1);
                idx++;
            end else begin
                i_valid = 1'b0;
                i_start = 1'($urandom_range(1));
                i_data  = 8'($urandom_range(255));
            end
            @(negedge clk);
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            checks++;
            if (o_valid0 !== exp_v || o_valid2 !== exp_v)
                $display("FAIL valid cyc=%0d: got %b/%b expected %b", cyc, o_valid0, o_valid2, exp_v);
            if (exp_v) begin
                e = pend_q.pop_front();
                void'(due_q.pop_front());
                checks++;
                if (o_data0 !== 8'(e.v0)) begin
                    failures++;
                    $display("FAIL data_shift0 cyc=%0d: got %0d expected %0d", cyc, o_data0, e.v0);
                end
                checks++;
                if (o_data2 !== 8'(e.v2)) begin
                    failures++;
                    $display("FAIL data_shift2 cyc=%0d: got %0d expected %0d", cyc, o_data2, e.v2);
                end
                checks++;
                if ({o_start0, o_end0, o_start2, o_end2} !== {e.os, e.oe, e.os, e.oe}) begin
                    failures++;
                    $display("FAIL start_end cyc=%0d: got %b%b%b%b expected %b%b", cyc,
                             o_start0, o_end0, o_start2, o_end2, e.os, e.oe);
                end
            end else begin
                checks++;
                if ({o_start0, o_end0, o_start2, o_end2} !== 4'b0000) begin
                    failures++;
                    $display("FAIL idle_markers cyc=%0d: got %b%b%b%b expected 0000", cyc,
                             o_start0, o_end0, o_start2, o_end2);
                end
            end
            if (o_valid0 !== exp_v || o_valid2 !== exp_v) failures++;
            exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
            if (exp_e) void'(err_q.pop_front());
            checks++;
            if ({o_err0, o_err2} !== {exp_e, exp_e}) begin
                failures++;
                $display("FAIL frame_err cyc=%0d: got %b%b expected %b", cyc, o_err0, o_err2, exp_e);
            end
            if (o_valid0 === 1'b1) out_cnt++;
            if (o_end0 === 1'b1) end_cnt++;
            if (o_err0 === 1'b1) err_cnt++;
        end
        checks++;
        if (guard >= 4000) begin
            failures++;
            $display("FAIL timeout: got %0d cycles expected fewer than 4000", guard);
        end
        evq.delete();
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_start = 1'b0; i_data = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_data0, o_data2, o_valid0, o_start0, o_end0, o_err0, o_valid2, o_start2, o_end2, o_err2} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%h %b%b%b%b expected all zero",
                     o_data0, o_data2, o_valid0, o_start0, o_end0, o_err0);
        end
        rst = 1'b0;
    endtask

    task automatic test_const();
        fill_image(0); add_junk(3); add_frame(W*H, 1'b0); play(0);
        checks++;
        if (out_cnt != 24 || end_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL const_counts: got out=%0d end=%0d err=%0d expected 24/1/0", out_cnt, end_cnt, err_cnt);
        end
    endtask

    task automatic test_step_and_ramp();
        fill_image(1); add_frame(W*H, 1'b0); play(0);
        checks++;
        if (out_cnt != 24) begin
            failures++;
            $display("FAIL step_count: got %0d expected 24", out_cnt);
        end
        fill_image(2); add_frame(W*H, 1'b0); play(0);
        checks++;
        if (out_cnt != 24 || end_cnt != 1) begin
            failures++;
            $display("FAIL ramp_counts: got out=%0d end=%0d expected 24/1", out_cnt, end_cnt);
        end
    endtask

    task automatic test_gaps();
        fill_image(0); add_frame(W*H, 1'b0); play(50);
        checks++;
        if (out_cnt != 24 || end_cnt != 1) begin
            failures++;
            $display("FAIL gaps_const_counts: got out=%0d end=%0d expected 24/1", out_cnt, end_cnt);
        end
        for (int n = 0; n < 3; n++) begin
            fill_image(3); add_frame(W*H, 1'b0); play(50);
            checks++;
            if (out_cnt != 24 || end_cnt != 1) begin
                failures++;
                $display("FAIL gaps_random_counts: got out=%0d end=%0d expected 24/1", out_cnt, end_cnt);
            end
        end
    endtask

    task automatic test_restart();
        fill_image(3); add_frame(3*W + 5, 1'b0);
        fill_image(3); add_frame(W*H, 1'b1);
        play(30);
        checks++;
        if (out_cnt != 33 || end_cnt != 1 || err_cnt != 1) begin
            failures++;
            $display("FAIL restart_counts: got out=%0d end=%0d err=%0d expected 33/1/1", out_cnt, end_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        fill_image(3); add_frame(W*H, 1'b0);
        fill_image(3); add_frame(W*H, 1'b0);
        play(0);
        checks++;
        if (out_cnt != 48 || end_cnt != 2 || err_cnt != 0) begin
            failures++;
            $display("FAIL b2b_counts: got out=%0d end=%0d err=%0d expected 48/2/0", out_cnt, end_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        fill_image(3); add_frame(W*H, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_start = evq[k].st; i_data = 8'(evq[k].d);
        end
        evq.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_data0, o_data2, o_valid0, o_start0, o_end0, o_err0, o_valid2, o_start2, o_end2, o_err2} !== 24'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h/%h %b%b%b%b expected all zero",
                     o_data0, o_data2, o_valid0, o_start0, o_end0, o_err0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_start = 1'b0; i_data = 8'($urandom_range(255));
            @(negedge clk);
            checks++;
            if ({o_valid0, o_valid2, o_end0, o_err0} !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset_quiet cyc=%0d: got %b%b%b%b expected 0000",
                         cyc, o_valid0, o_valid2, o_end0, o_err0);
            end
        end
        fill_image(3); add_frame(W*H, 1'b0); play(20);
        checks++;
        if (out_cnt != 24 || end_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL reset_recover_counts: got out=%0d end=%0d err=%0d expected 24/1/0", out_cnt, end_cnt, err_cnt);
        end
    endtask

`ifdef SOBEL_THRESH_EN
    task automatic test_thresh();
        int tv [3];
        tv[0] = 200; tv[1] = 255; tv[2] = 0;
        thr_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            thr = tv[n];
            i_thresh = 8'(tv[n]);
            fill_image(1); add_frame(W*H, 1'b0); play(0);
            checks++;
            if (out_cnt != 24) begin
                failures++;
                $display("FAIL thresh_count: got %0d expected 24", out_cnt);
            end
        end
        thr_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_const();
        test_step_and_ramp();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_reset_mid();
`ifdef SOBEL_THRESH_EN
        test_thresh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
Parametrised streaming 3x3 Sobel edge detector, and the next generation of the team's fixed-size Sobel block. Image width, height, pixel width and magnitude scaling are parameters. Input is a valid-qualified pixel stream with gaps allowed. Two internal line buffers form the 3x3 window. Output is the saturated |Gx|+|Gy| magnitude for every interior pixel, plus frame start/end markers. It sits between the frame source (SDRAM reader) and the output writer.

Parameters:
DATA_W, 8, pixel width in bits, input and output.
IMG_W, 640, pixels per line (>=3).
IMG_H, 480, lines per frame (>=3).
MAG_SHIFT, 0, right shift applied to |Gx|+|Gy| before saturation (0..4).

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  reset; asynchronous, active-high.
iStart  in  1  marks the first pixel (row 0, col 0) of a frame; qualified by iValid.
iValid  in  1  iData valid this cycle. No backpressure: a pixel is accepted every cycle iValid=1.
iData  in  DATA_W  pixel, raster order.
oData  out  DATA_W  edge magnitude.
oValid  out  1  oData valid.
oStart  out  1  high with the first output pixel of a frame.
oEnd  out  1  high with the last output pixel of a frame.
oFrameErr  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pipeline valids cleared. Line buffer contents are don't-care.
- States:
  - IDLE: iValid&iStart → ACTIVE and accept the pixel as (0,0). iValid without iStart is ignored.
  - ACTIVE: each accepted pixel advances col; at col=IMG_W-1, col wraps to 0 and row increments.
  - Accepting (IMG_H-1, IMG_W-1) → IDLE.
- Restart: iValid&iStart while ACTIVE aborts the frame. oFrameErr pulses next cycle, the pixel becomes (0,0) of a new frame, and the state stays ACTIVE. Results already in the pipeline still emerge, but oEnd is not asserted for the aborted frame.
- Line buffers: two IMG_W-deep shift/RAM buffers holding rows r-1 and r-2. They are written only on accepted pixels. iValid=0 freezes the window and line buffers.
- Window: a pixel accepted at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1). Only these windows produce output. Output count per frame is (IMG_W-2)*(IMG_H-2), and border pixels are not output.
- Arithmetic, with p[y][x] over window rows 0..2 (top to bottom) and cols 0..2 (left to right):
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Gx and Gy are signed, DATA_W+3 bits.
  - mag = (|Gx|+|Gy|) >> MAG_SHIFT, unsigned DATA_W+4 bits.
  - oData = min(mag, 2^DATA_W-1).
- Pipeline: 3 registered stages (window capture, Gx/Gy, abs/sum/shift/saturate). A completing pixel accepted at cycle t gives oValid=1 at t+3.
  - The pipeline advances every cycle regardless of iValid, so gaps in iValid appear as gaps in oValid.
  - Latency is fixed at 3.
- oStart = oValid for centre (1,1). oEnd = oValid for centre (IMG_H-2, IMG_W-2).
- Reset mid-frame: immediate return to IDLE, all in-flight results discarded, and no oEnd.

Optional Feature:
SOBEL_THRESH_EN
- Defined: adds input port iThresh (DATA_W). Output becomes binary: oData = all-ones if saturated mag >= iThresh, else 0. iThresh is sampled in the stage-3 cycle, and latency is unchanged.
- Undefined: no iThresh port; oData is the saturated magnitude.

Test Plan:
1. IMG_W=8, IMG_H=6, constant pixel 50, iValid=1 continuous → 24 outputs all 0. oStart on the 1st output, oEnd on the 24th, first oValid 3 cycles after pixel (2,2) is accepted.
2. Vertical step (cols 0-3 = 0, cols 4-7 = 100) → centres at cols 3 and 4 give Gx=400, saturated to 255. All other outputs 0.
3. Horizontal ramp pixel = 10*col → every output = 80. Repeat with MAG_SHIFT=2 and the step image → outputs at cols 3/4 = 100.
4. Scenario 1 with iValid randomly deasserted 50% of cycles → identical oData sequence and still 24 outputs. Each oValid lands exactly 3 cycles after its completing accepted pixel.
5. iStart reasserted at pixel (3,5) → oFrameErr single pulse. The new frame completes normally with 24 outputs and one oEnd. rst_i pulsed mid-frame → all outputs 0 immediately, no further oValid until the next iStart.
6. SOBEL_THRESH_EN defined, step image, iThresh=200 → 255 at cols 3/4, else 0. iThresh=255 → 255. iThresh=0 → all outputs 255.
